// File: rtl/seven_segment_reader.sv
// rtl/seven_segment_reader.sv - captures scanned 7-segment digits back into a BCD frame
// Optional: define SEVSEG_ERRCNT_EN to add the saturating err_cnt output.
module seven_segment_reader #(
    parameter int DIGITS = 4,
    parameter int STABLE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            seg,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     dp,
    output logic                  valid,
`ifdef SEVSEG_ERRCNT_EN
    output logic [7:0]            err_cnt,
`endif
    output logic                  err
);

    localparam int CW = $clog2(STABLE);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE - 1);

    logic [DIGITS-1:0]   an_q;
    logic [7:0]          seg_q;
    logic [CW-1:0]       cnt;
    logic                taken;
    logic [DIGITS-1:0]   seen;
    logic                frame_err;
    logic [4*DIGITS-1:0] slot_val;
    logic [DIGITS-1:0]   slot_dp;

    logic                changed;
    logic                capture;
    logic                complete;
    logic [3:0]          nib;
    logic                bad;
    logic [DIGITS-1:0]   seen_base;
    logic                ferr_base;

    function automatic logic one_low(input logic [DIGITS-1:0] a);
        int n;
        n = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!a[i]) n++;
        end
        return (n == 1);
    endfunction

    always_comb begin
        nib = 4'hF;
        bad = 1'b1;
        case (seg_q[6:0])
            7'h40: begin nib = 4'd0; bad = 1'b0; end
            7'h79: begin nib = 4'd1; bad = 1'b0; end
            7'h24: begin nib = 4'd2; bad = 1'b0; end
            7'h30: begin nib = 4'd3; bad = 1'b0; end
            7'h19: begin nib = 4'd4; bad = 1'b0; end
            7'h12: begin nib = 4'd5; bad = 1'b0; end
            7'h02: begin nib = 4'd6; bad = 1'b0; end
            7'h78: begin nib = 4'd7; bad = 1'b0; end
            7'h00: begin nib = 4'd8; bad = 1'b0; end
            7'h10: begin nib = 4'd9; bad = 1'b0; end
            default: begin nib = 4'hF; bad = 1'b1; end
        endcase
    end

    // Capture looks only at registered state, so the edge after a full stable run commits.
    assign changed   = ({an, seg} != {an_q, seg_q});
    assign capture   = (cnt == CNT_MAX) && !taken && one_low(an_q);
    assign complete  = &seen;
    assign seen_base = complete ? '0 : seen;
    assign ferr_base = complete ? 1'b0 : frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q      <= '1;
            seg_q     <= 8'hFF;
            cnt       <= '0;
            taken     <= 1'b0;
            seen      <= '0;
            frame_err <= 1'b0;
            slot_val  <= '0;
            slot_dp   <= '0;
            value     <= '0;
            dp        <= '0;
            valid     <= 1'b0;
            err       <= 1'b0;
`ifdef SEVSEG_ERRCNT_EN
            err_cnt   <= 8'd0;
`endif
        end else begin
            an_q  <= an;
            seg_q <= seg;

            if (changed) begin
                cnt   <= '0;
                taken <= 1'b0;
            end else begin
                if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                if (capture) taken <= 1'b1;
            end

            valid <= complete;
            if (complete) begin
                value <= slot_val;
                dp    <= slot_dp;
                err   <= frame_err;
            end
`ifdef SEVSEG_ERRCNT_EN
            if (complete && frame_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
`endif

            // A capture on the completion edge belongs to the next frame.
            if (capture) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (!an_q[i]) begin
                        slot_val[4*i +: 4] <= nib;
                        slot_dp[i]         <= ~seg_q[7];
                    end
                end
                seen      <= seen_base | ~an_q;
                frame_err <= ferr_base | bad;
            end else begin
                seen      <= seen_base;
                frame_err <= ferr_base;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_reader.sv
// tb/tb_seven_segment_reader.sv - scoreboard bench for seven_segment_reader
module tb_seven_segment_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        valid;
    logic        err;
`ifdef SEVSEG_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int valid_cnt = 0;
    logic prev_valid = 1'b0;
    logic [20:0] sb[$];

    always #5 clk = ~clk;

    seven_segment_reader #(.DIGITS(4), .STABLE(4)) dut (
        .clk(clk),
        .rst(rst),
        .seg(seg),
        .an(an),
        .value(value),
        .dp(dp),
        .valid(valid),
`ifdef SEVSEG_ERRCNT_EN
        .err_cnt(err_cnt),
`endif
        .err(err)
    );

    // Output monitor: every valid pulse is matched against the scoreboard.
    always @(negedge clk) begin
        logic [20:0] exp;
        if (valid === 1'b1) begin
            valid_cnt++;
            checks++;
            if (prev_valid) begin
                failures++;
                $display("FAIL valid_consecutive got=1 want=0");
            end
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid value=%h dp=%h err=%b want=no_pulse", value, dp, err);
            end else begin
                exp = sb.pop_front();
                if ({value, dp, err} !== exp)
                begin
                    failures++;
                    $display("FAIL frame value=%h dp=%h err=%b want value=%h dp=%h err=%b",
                             value, dp, err, exp[20:5], exp[4:1], exp[0]);
                end
            end
        end
        prev_valid = (valid === 1'b1);
    end

    task automatic hold_in(input logic [3:0] a, input logic [7:0] s, input int n);
        an  = a;
        seg = s;
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic scan(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                        input logic [7:0] s3, input int hold, input int gap);
        hold_in(4'b1110, s0, hold); hold_in(4'b1111, 8'hFF, gap);
        hold_in(4'b1101, s1, hold); hold_in(4'b1111, 8'hFF, gap);
        hold_in(4'b1011, s2, hold); hold_in(4'b1111, 8'hFF, gap);
        hold_in(4'b0111, s3, hold); hold_in(4'b1111, 8'hFF, gap);
    endtask

    task automatic wait_drain(input string name);
        an  = 4'b1111;
        seg = 8'hFF;
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout pending=%0d want=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        an  = 4'b1111;
        seg = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_pulses(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s_pulses got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            an  = 4'($urandom);
            seg = 8'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if ({value, dp, valid, err} !== 22'd0) begin
                failures++;
                $display("FAIL reset_hold value=%h dp=%h valid=%b err=%b want all 0", value, dp, valid, err);
            end
        end
        rst = 1'b0;
        an  = 4'b1111;
        seg = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({value, dp, valid, err} !== 22'd0) begin
            failures++;
            $display("FAIL reset_after value=%h dp=%h valid=%b err=%b want all 0", value, dp, valid, err);
        end
`ifdef SEVSEG_ERRCNT_EN
        checks++;
        if (err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_err_cnt got=%0d want=0", err_cnt);
        end
`endif
    endtask

    task automatic test_normal();
        int base;
        reset_dut();
        base = valid_cnt;
        sb.push_back({16'h4321, 4'h0, 1'b0});
        scan(8'hF9, 8'hA4, 8'hB0, 8'h99, 8, 2);
        wait_drain("normal");
        check_pulses("normal", valid_cnt - base, 1);
    endtask

    task automatic test_short_hold();
        int base;
        reset_dut();
        base = valid_cnt;
        hold_in(4'b1110, 8'h00, 8); hold_in(4'b1111, 8'hFF, 2);
        hold_in(4'b1101, 8'h00, 3); hold_in(4'b1111, 8'hFF, 2);
        hold_in(4'b1011, 8'h00, 8); hold_in(4'b1111, 8'hFF, 2);
        hold_in(4'b0111, 8'h00, 8); hold_in(4'b1111, 8'hFF, 10);
        check_pulses("short_hold", valid_cnt - base, 0);
        sb.push_back({16'h8888, 4'hF, 1'b0});
        scan(8'h00, 8'h00, 8'h00, 8'h00, 8, 2);
        wait_drain("short_full");
        check_pulses("short_full", valid_cnt - base, 1);
    endtask

    task automatic test_bad_pattern();
        int base;
        reset_dut();
        base = valid_cnt;
        sb.push_back({16'h0F00, 4'h0, 1'b1});
        scan(8'hC0, 8'hC0, 8'hA5, 8'hC0, 8, 2);
        sb.push_back({16'h4321, 4'h0, 1'b0});
        scan(8'hF9, 8'hA4, 8'hB0, 8'h99, 8, 2);
        wait_drain("bad");
        check_pulses("bad", valid_cnt - base, 2);
`ifdef SEVSEG_ERRCNT_EN
        checks++;
        if (err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL bad_err_cnt got=%0d want=1", err_cnt);
        end
`endif
    endtask

    task automatic test_multi_hot();
        int base;
        reset_dut();
        base = valid_cnt;
        sb.push_back({16'h4321, 4'h0, 1'b0});
        hold_in(4'b1110, 8'hF9, 8);  hold_in(4'b1111, 8'hFF, 2);
        hold_in(4'b1101, 8'hA4, 8);  hold_in(4'b1111, 8'hFF, 2);
        hold_in(4'b1100, 8'hF8, 10); hold_in(4'b1111, 8'hFF, 4);
        check_pulses("multi_hot_mid", valid_cnt - base, 0);
        hold_in(4'b1011, 8'hB0, 8);  hold_in(4'b1111, 8'hFF, 2);
        hold_in(4'b0111, 8'h99, 8);  hold_in(4'b1111, 8'hFF, 2);
        wait_drain("multi_hot");
        check_pulses("multi_hot", valid_cnt - base, 1);
    endtask

    task automatic test_reset_mid();
        int base;
        reset_dut();
        base = valid_cnt;
        hold_in(4'b1110, 8'h92, 8); hold_in(4'b1111, 8'hFF, 2);
        hold_in(4'b1101, 8'h82, 8); hold_in(4'b1111, 8'hFF, 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.push_back({16'h1789, 4'h0, 1'b0});
        scan(8'h90, 8'h80, 8'hF8, 8'hF9, 8, 2);
        wait_drain("reset_mid");
        check_pulses("reset_mid", valid_cnt - base, 1);
    endtask

    task automatic test_back_to_back();
        int base;
        reset_dut();
        base = valid_cnt;
        sb.push_back({16'h5678, 4'h8, 1'b0});
        sb.push_back({16'h9012, 4'h5, 1'b0});
        scan(8'h80, 8'hF8, 8'h82, 8'h12, 4, 0);
        scan(8'h24, 8'hF9, 8'h40, 8'h90, 4, 0);
        wait_drain("back_to_back");
        check_pulses("back_to_back", valid_cnt - base, 2);
    endtask

    initial begin
        rst = 1'b1;
        an  = 4'b1111;
        seg = 8'hFF;
        test_reset();
        test_normal();
        test_short_hold();
        test_bad_pattern();
        test_multi_hot();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
